// File: rtl/pca9548_arb.sv
// NCH-client IIC arbiter in front of one IIC_CTL, reprogramming a PCA9548 switch only when the granted code differs.
// Define PCA9548_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module pca9548_arb #(
  parameter int              NCH        = 4,
  parameter logic [6:0]      PCA9548_AD = 7'h74,
  parameter logic [NCH*8-1:0] SEL_CODES = {8'h08, 8'h04, 8'h02, 8'h01},
  parameter logic [7:0]      INIT_SEL   = 8'h18,
  parameter int              INIT_DELAY = 128
) (
  input  logic             CLK_IN,
  input  logic             RESET_IN,
  output logic             INIT_ERR_OUT,
  input  logic [NCH-1:0]   CH_REQ_IN,
  input  logic [8*NCH-1:0] CH_NUM_IN,
  input  logic [7*NCH-1:0] CH_DAD_IN,
  input  logic [8*NCH-1:0] CH_ADR_IN,
  input  logic [NCH-1:0]   CH_RNW_IN,
  input  logic [8*NCH-1:0] CH_WDT_IN,
  output logic [NCH-1:0]   CH_RAK_OUT,
  output logic [NCH-1:0]   CH_WDA_OUT,
  output logic [NCH-1:0]   CH_WAE_OUT,
  output logic [NCH-1:0]   CH_BSY_OUT,
  output logic [NCH-1:0]   CH_RVL_OUT,
  output logic [NCH-1:0]   CH_EOR_OUT,
  output logic [NCH-1:0]   CH_ERR_OUT,
  output logic [8*NCH-1:0] CH_RDT_OUT,
  output logic [7:0]       MUX_CODE_OUT,
  output logic             MUX_VLD_OUT,
  output logic             IIC_REQ_OUT,
  output logic             IIC_NOA_OUT,
  output logic             IIC_RNW_OUT,
  output logic [7:0]       IIC_NUM_OUT,
  output logic [7:0]       IIC_ADR_OUT,
  output logic [7:0]       IIC_WDT_OUT,
  output logic [6:0]       IIC_DAD_OUT,
  input  logic             IIC_RAK_IN,
  input  logic             IIC_WDA_IN,
  input  logic             IIC_WAE_IN,
  input  logic             IIC_BSY_IN,
  input  logic             IIC_RVL_IN,
  input  logic             IIC_EOR_IN,
  input  logic             IIC_ERR_IN,
  input  logic [7:0]       IIC_RDT_IN
);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    INIT_WAIT, INIT_REQ, INIT_RUN, IDLE, MUX_REQ, MUX_RUN, XFR_REQ, XFR_RUN
  } state_t;

  state_t           state_q;
  logic [15:0]      cnt_q;
  logic [GW-1:0]    g_q;
  logic             err_seen_q;
  logic             init_err_q, mux_vld_q;
  logic [7:0]       mux_code_q;
  logic [NCH-1:0]   ch_rak_q, ch_wda_q, ch_wae_q, ch_bsy_q, ch_rvl_q, ch_eor_q, ch_err_q;
  logic [8*NCH-1:0] ch_rdt_q;
  logic             iic_req_q, iic_noa_q, iic_rnw_q;
  logic [7:0]       iic_num_q, iic_adr_q, iic_wdt_q;
  logic [6:0]       iic_dad_q;
  logic [7:0]       lat_num_q, lat_adr_q;
  logic [6:0]       lat_dad_q;
  logic             lat_rnw_q;

  logic [NCH-1:0]   cand;
  logic [GW-1:0]    win;
  logic             win_vld;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
    assign cand[gi] = CH_REQ_IN[gi] & ~ch_bsy_q[gi];
  end

`ifdef PCA9548_ARB_RR_EN
  logic [GW-1:0] ptr_q;
  int            idx;

  // Walk from the pointer upward with wrap; iterating backwards leaves the nearest candidate as winner.
  always_comb begin
    win     = '0;
    win_vld = |cand;
    idx     = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (cand[idx]) win = GW'(idx);
    end
  end
`else
  always_comb begin
    win     = '0;
    win_vld = |cand;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (cand[k]) win = GW'(k);
    end
  end
`endif

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_q    <= INIT_WAIT;
      cnt_q      <= '0;
      g_q        <= '0;
      err_seen_q <= 1'b0;
      init_err_q <= 1'b0;
      mux_vld_q  <= 1'b0;
      mux_code_q <= 8'h00;
      ch_rak_q   <= '0;
      ch_wda_q   <= '0;
      ch_wae_q   <= '0;
      ch_bsy_q   <= '0;
      ch_rvl_q   <= '0;
      ch_eor_q   <= '0;
      ch_err_q   <= '0;
      ch_rdt_q   <= '0;
      iic_req_q  <= 1'b0;
      iic_noa_q  <= 1'b0;
      iic_rnw_q  <= 1'b0;
      iic_num_q  <= '0;
      iic_adr_q  <= '0;
      iic_wdt_q  <= '0;
      iic_dad_q  <= '0;
      lat_num_q  <= '0;
      lat_adr_q  <= '0;
      lat_dad_q  <= '0;
      lat_rnw_q  <= 1'b0;
`ifdef PCA9548_ARB_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      ch_rak_q <= '0;
      ch_wda_q <= '0;
      ch_wae_q <= '0;
      ch_rvl_q <= '0;
      ch_eor_q <= '0;
      case (state_q)
        INIT_WAIT: begin
          cnt_q <= cnt_q + 16'd1;
          if (cnt_q == 16'(INIT_DELAY - 1)) begin
            state_q   <= INIT_REQ;
            iic_req_q <= 1'b1;
            iic_noa_q <= 1'b1;
            iic_rnw_q <= 1'b0;
            iic_num_q <= 8'h00;
            iic_adr_q <= 8'h00;
            iic_dad_q <= PCA9548_AD;
            iic_wdt_q <= INIT_SEL;
          end
        end
        INIT_REQ, MUX_REQ: begin
          if (IIC_RAK_IN) begin
            iic_req_q  <= 1'b0;
            err_seen_q <= IIC_ERR_IN & IIC_BSY_IN;
            state_q    <= (state_q == INIT_REQ) ? INIT_RUN : MUX_RUN;
          end
        end
        INIT_RUN: begin
          if (IIC_BSY_IN) begin
            if (IIC_ERR_IN) err_seen_q <= 1'b1;
          end else begin
            if (err_seen_q) begin
              init_err_q <= 1'b1;
              mux_vld_q  <= 1'b0;
            end else begin
              mux_code_q <= INIT_SEL;
              mux_vld_q  <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (win_vld) begin
            g_q           <= win;
            ch_rak_q[win] <= 1'b1;
            ch_bsy_q[win] <= 1'b1;
            ch_err_q[win] <= 1'b0;
            lat_num_q     <= CH_NUM_IN[8*win +: 8];
            lat_dad_q     <= CH_DAD_IN[7*win +: 7];
            lat_adr_q     <= CH_ADR_IN[8*win +: 8];
            lat_rnw_q     <= CH_RNW_IN[win];
            iic_req_q     <= 1'b1;
            if (mux_vld_q && (mux_code_q == SEL_CODES[8*win +: 8])) begin
              state_q   <= XFR_REQ;
              iic_noa_q <= 1'b0;
              iic_rnw_q <= CH_RNW_IN[win];
              iic_num_q <= CH_NUM_IN[8*win +: 8];
              iic_adr_q <= CH_ADR_IN[8*win +: 8];
              iic_dad_q <= CH_DAD_IN[7*win +: 7];
              iic_wdt_q <= CH_WDT_IN[8*win +: 8];
            end else begin
              state_q   <= MUX_REQ;
              iic_noa_q <= 1'b1;
              iic_rnw_q <= 1'b0;
              iic_num_q <= 8'h00;
              iic_adr_q <= 8'h00;
              iic_dad_q <= PCA9548_AD;
              iic_wdt_q <= SEL_CODES[8*win +: 8];
            end
          end
        end
        MUX_RUN: begin
          if (IIC_BSY_IN) begin
            if (IIC_ERR_IN) err_seen_q <= 1'b1;
          end else if (err_seen_q) begin
            ch_err_q[g_q] <= 1'b1;
            ch_bsy_q[g_q] <= 1'b0;
            mux_vld_q     <= 1'b0;
            state_q       <= IDLE;
          end else begin
            mux_code_q <= SEL_CODES[8*g_q +: 8];
            mux_vld_q  <= 1'b1;
            state_q    <= XFR_REQ;
            iic_req_q  <= 1'b1;
            iic_noa_q  <= 1'b0;
            iic_rnw_q  <= lat_rnw_q;
            iic_num_q  <= lat_num_q;
            iic_adr_q  <= lat_adr_q;
            iic_dad_q  <= lat_dad_q;
            iic_wdt_q  <= CH_WDT_IN[8*g_q +: 8];
          end
        end
        XFR_REQ: begin
          iic_wdt_q <= CH_WDT_IN[8*g_q +: 8];
          if (IIC_RAK_IN) begin
            iic_req_q  <= 1'b0;
            err_seen_q <= IIC_ERR_IN & IIC_BSY_IN;
            state_q    <= XFR_RUN;
          end
        end
        XFR_RUN: begin
          // Controller strobes are steered only to the granted channel.
          iic_wdt_q     <= CH_WDT_IN[8*g_q +: 8];
          ch_wda_q[g_q] <= IIC_WDA_IN;
          ch_wae_q[g_q] <= IIC_WAE_IN;
          ch_rvl_q[g_q] <= IIC_RVL_IN;
          ch_eor_q[g_q] <= IIC_EOR_IN;
          if (IIC_RVL_IN) ch_rdt_q[8*g_q +: 8] <= IIC_RDT_IN;
          if (IIC_BSY_IN) begin
            if (IIC_ERR_IN) err_seen_q <= 1'b1;
          end else begin
            if (err_seen_q) ch_err_q[g_q] <= 1'b1;
            ch_bsy_q[g_q] <= 1'b0;
            state_q       <= IDLE;
`ifdef PCA9548_ARB_RR_EN
            ptr_q <= (g_q == GW'(NCH - 1)) ? '0 : g_q + 1'b1;
`endif
          end
        end
        default: state_q <= INIT_WAIT;
      endcase
    end
  end

  assign INIT_ERR_OUT = init_err_q;
  assign MUX_CODE_OUT = mux_code_q;
  assign MUX_VLD_OUT  = mux_vld_q;
  assign CH_RAK_OUT   = ch_rak_q;
  assign CH_WDA_OUT   = ch_wda_q;
  assign CH_WAE_OUT   = ch_wae_q;
  assign CH_BSY_OUT   = ch_bsy_q;
  assign CH_RVL_OUT   = ch_rvl_q;
  assign CH_EOR_OUT   = ch_eor_q;
  assign CH_ERR_OUT   = ch_err_q;
  assign CH_RDT_OUT   = ch_rdt_q;
  assign IIC_REQ_OUT  = iic_req_q;
  assign IIC_NOA_OUT  = iic_noa_q;
  assign IIC_RNW_OUT  = iic_rnw_q;
  assign IIC_NUM_OUT  = iic_num_q;
  assign IIC_ADR_OUT  = iic_adr_q;
  assign IIC_WDT_OUT  = iic_wdt_q;
  assign IIC_DAD_OUT  = iic_dad_q;

endmodule

// File: doc/pca9548_arb.md
Name: pca9548_arb

Overview:
- Parametrised successor to the fixed two-channel PCA9548 switch front-end.
- Arbitrates NCH client IIC request ports onto one IIC_CTL-style controller port.
- Each client channel owns a PCA9548 select code. The mux is reprogrammed only when the granted channel's code differs from the code currently latched in the switch.
- Sits between board-level IIC clients (clock synth, SFP, EEPROM) and the single IIC_CTL instance driving SCL/SDA.

Parameters:
- NCH, 4: number of client channels, 2..8.
- PCA9548_AD, 7'h74: PCA9548 device address.
- SEL_CODES, {8'h08,8'h04,8'h02,8'h01}: packed NCH*8 select codes; channel i uses bits [8i+7:8i].
- INIT_SEL, 8'h18: code written to the switch after reset.
- INIT_DELAY, 128: cycles from reset release to the initial switch write, 1..65535.

Ports:
- CLK_IN  in  1  system clock
- RESET_IN  in  1  reset
- INIT_ERR_OUT  out  1  initial switch write failed; sticky
- CH_REQ_IN  in  NCH  per-channel request
- CH_NUM_IN  in  8*NCH  access count-1
- CH_DAD_IN  in  7*NCH  device address
- CH_ADR_IN  in  8*NCH  word address
- CH_RNW_IN  in  NCH  read(1)/write(0)
- CH_WDT_IN  in  8*NCH  write data
- CH_RAK_OUT, CH_WDA_OUT, CH_WAE_OUT, CH_BSY_OUT, CH_RVL_OUT, CH_EOR_OUT, CH_ERR_OUT  out  NCH each  per-channel status/strobes
- CH_RDT_OUT  out  8*NCH  read data, held between strobes
- MUX_CODE_OUT  out  8  code currently believed in the switch
- MUX_VLD_OUT  out  1  MUX_CODE_OUT is trustworthy
- IIC_REQ_OUT, IIC_NOA_OUT, IIC_RNW_OUT  out  1  to controller
- IIC_NUM_OUT, IIC_ADR_OUT, IIC_WDT_OUT  out  8  to controller
- IIC_DAD_OUT  out  7  to controller
- IIC_RAK_IN, IIC_WDA_IN, IIC_WAE_IN, IIC_BSY_IN, IIC_RVL_IN, IIC_EOR_IN, IIC_ERR_IN  in  1  from controller
- IIC_RDT_IN  in  8  from controller

Behaviour:

Clocking and reset:
- One clock, CLK_IN. Reset is synchronous and active-high on RESET_IN.
- All outputs reset to 0, except MUX_CODE_OUT=8'h00 and MUX_VLD_OUT=0. State resets to INIT_WAIT and the arbitration pointer resets to 0.
- Reset mid-operation aborts immediately; no bus cleanup is attempted.

Controller contract:
- IIC_BSY_IN is high no later than the cycle IIC_RAK_IN is high.
- A run ends on the first cycle IIC_BSY_IN=0 after RAK.

States:
- INIT_WAIT: count INIT_DELAY cycles, then go to INIT_REQ.
- INIT_REQ: IIC_REQ_OUT=1 with DAD=PCA9548_AD, NOA=1, RNW=0, NUM=0, WDT=INIT_SEL. Hold until IIC_RAK_IN, then go to INIT_RUN.
- INIT_RUN: at end, if IIC_ERR_IN was seen while busy, set INIT_ERR_OUT (sticky until reset) and MUX_VLD_OUT=0. Otherwise MUX_CODE_OUT=INIT_SEL and MUX_VLD_OUT=1. Go to IDLE in both cases.
- IDLE: candidates are CH_REQ_IN[i] & ~CH_BSY_OUT[i]. Pick the winner g per the arbitration rule.
  - Next cycle: CH_RAK_OUT[g]=1 for exactly 1 cycle, CH_BSY_OUT[g]=1, CH_ERR_OUT[g] cleared.
  - Latch NUM/DAD/ADR/RNW of channel g.
  - If MUX_VLD_OUT and MUX_CODE_OUT==SEL_CODES[g], go to XFR_REQ; else go to MUX_REQ.
- MUX_REQ: same as INIT_REQ but with WDT=SEL_CODES[g]; then go to MUX_RUN.
- MUX_RUN: at end, on error: CH_ERR_OUT[g]=1, MUX_VLD_OUT=0, CH_BSY_OUT[g]=0, go to IDLE. On success: MUX_CODE_OUT=SEL_CODES[g], MUX_VLD_OUT=1, go to XFR_REQ.
- XFR_REQ: IIC_REQ_OUT=1 with the latched channel fields and NOA=0. Hold until IIC_RAK_IN, then go to XFR_RUN.
- XFR_RUN:
  - IIC_WDA/WAE/RVL/EOR_IN are forwarded to bit g only, registered, 1-cycle latency.
  - CH_RDT_OUT[g] loads on RVL.
  - IIC_WDT_OUT = CH_WDT_IN[g] registered.
  - At end: CH_ERR_OUT[g] is set if IIC_ERR_IN was seen while busy. CH_BSY_OUT[g]=0. Pointer=(g+1) mod NCH. Go to IDLE.
  - An error during XFR does not invalidate the mux code.

Output rules:
- CH_ERR_OUT is sticky until that channel's next RAK.
- Outputs for non-granted channels stay 0; their RDT holds its value.
- During INIT/MUX phases no channel strobes are forwarded.
- A request arriving during a busy period waits; CH_REQ_IN is level-sampled only in IDLE.
- Requests are accepted even when INIT_ERR_OUT=1. Such requests always take the MUX_REQ path.
- Minimum IDLE dwell is 1 cycle between grants.

Optional Feature:
- Macro PCA9548_ARB_RR_EN.
- Defined: round-robin. The search starts at the pointer and wraps, so with all channels requesting the grant order is 0,1,2,3,0.
- Undefined: fixed priority, lowest index wins, and the pointer logic is removed.

Test Plan:
- Reset release, INIT_DELAY=128 -> IIC_REQ_OUT rises at cycle 129 with DAD=7'h74, NOA=1, WDT=8'h18. On success, MUX_CODE_OUT=8'h18 and MUX_VLD_OUT=1.
- Init write with IIC_ERR_IN pulsed -> INIT_ERR_OUT=1 stays high. A following ch0 request goes through MUX_REQ with WDT=8'h01, then XFR.
- ch1 write NUM=2 (3 bytes), switch code already 8'h02 -> no mux write. Three CH_WDA_OUT[1] pulses, the last with CH_WAE_OUT[1]. CH_BSY_OUT[1] drops when the controller goes idle.
- ch2 read NUM=1 after ch0 is served -> mux write of 8'h04, then two CH_RVL_OUT[2] pulses with RDT 8'hA5, 8'h5A and EOR on the second. CH_RDT_OUT[0] is unchanged.
- All four channels requesting continuously, RR_EN defined -> RAK order 0,1,2,3,0. RR_EN undefined -> ch0 granted on every arbitration.
- ch3 transfer with IIC_ERR_IN -> CH_ERR_OUT[3]=1, held until the next ch3 RAK, then cleared. MUX_VLD_OUT stays 1.
